mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (I) and load/store (D).
//  Arbitrates requests, sequences the memory handshake and returns acks and read data.
//  Produces cpu_stall for pc/regfile write-enable gating.
//  Reports bus-timeout access faults into the CPU exception mux.
// PARAMETERS
//  MAX_D_BURST     4   consecutive D grants allowed while I is waiting; the next grant then goes to I
//  TIMEOUT_CYCLES  16  cycles a granted access may wait for m_ack (MEM_ARB_TIMEOUT_EN only)
// PORTS
//  clk        in   1   clock; all logic on rising edge
//  rst        in   1   asynchronous, active-high reset
//  i_req      in   1   fetch request; held until i_ack
//  i_addr     in   64  fetch address; stable while i_req
//  i_ack      out  1   one-cycle pulse: fetch complete
//  i_rdata    out  32  instruction; valid only with i_ack
//  d_req      in   1   data request; held until d_ack
//  d_we       in   1   1=store, 0=load
//  d_addr     in   64  data address
//  d_wdata    in   64  store data
//  d_sel      in   8   byte enables
//  d_ack      out  1   one-cycle pulse: data access complete
//  d_rdata    out  64  load data; valid only with d_ack
//  m_req      out  1   memory request; held until m_ack
//  m_we, m_addr, m_wdata, m_sel  out  1/64/64/8  muxed attributes of the granted requester
//  m_ack      in   1   memory completion; m_rdata valid this cycle
//  m_rdata    in   64  memory read data
//  cpu_stall  out  1   = (i_req & ~i_ack) | (d_req & ~d_ack)
//  exc_en     out  1   one-cycle access-fault pulse
//  exc_code   out  4   1=instr, 5=load, 7=store access fault
//  exc_val    out  64  faulting address
// BEHAVIOUR
//  - Reset values: state=IDLE, m_req=0, i_ack=d_ack=0, exc_en=0, exc_code=0, exc_val=0,
//    burst_cnt=0, tmo_cnt=0. m_addr, m_wdata, m_sel, m_we=0. rdata outputs=0 when not acked.
//  - FSM states:
//      IDLE   -> GNT_D if d_req & ~(i_req & burst_cnt==MAX_D_BURST)
//             -> else GNT_I if i_req
//      GNT_x  -> on m_ack: re-arbitrate with the same rule, giving GNT_D, GNT_I or IDLE
//                (no bubble between back-to-back grants)
//  - Latency: request first seen in cycle N gives m_req=1 in cycle N+1 (registered grant).
//    x_ack = (state==GNT_x) & m_ack, combinational, same cycle as m_ack.
//    x_rdata is passed through from m_rdata; i_rdata = m_rdata[31:0].
//  - Minimum access time: 2 cycles.
//  - Attributes: m_* are muxed from the granted requester while in GNT_x. m_req=1 in every GNT state.
//  - Priority: D over I, because the pending D belongs to the instruction already fetched.
//  - burst_cnt: increments on each D grant made while i_req=1; saturates at MAX_D_BURST;
//    clears on an I grant.
//  - Simultaneous events:
//      m_ack together with both requests pending gives one ack out, then the next grant in the following cycle.
//      m_ack in IDLE is ignored.
//  - Protocol: dropping x_req or changing attributes before x_ack is illegal; the bench flags it.
//    The arbiter's behaviour in that case is undefined but it does not lock up.
//  - Reset mid-access: immediate return to IDLE and m_req=0. Memory drops the abandoned access.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - tmo_cnt clears on each grant and counts cycles in GNT_x without m_ack.
//   - When tmo_cnt reaches TIMEOUT_CYCLES in cycle T, the access is aborted:
//       x_ack=1 with x_rdata=0 in cycle T
//       exc_en=1 registered in cycle T+1, with exc_code and exc_val=x_addr
//       m_req=0 and state=IDLE from cycle T+1
//  MEM_ARB_TIMEOUT_EN undefined:
//   - No counter; the arbiter waits indefinitely.
//   - exc_en, exc_code and exc_val are tied 0.
// STRUCTURE
//  - cpu_pkg: arbiter state encoding (IDLE/GNT_I/GNT_D), EXC_INSTR_ACCESS=1,
//    EXC_LOAD_ACCESS=5, EXC_STORE_ACCESS=7.
//  - Sub-module mem_arb_timer holds tmo_cnt: inputs clear and enable, output expired.
//    It is instantiated only under MEM_ARB_TIMEOUT_EN.
// TESTING
//  1 I only:
//    i_req, i_addr=0x1000, memory acks after 2 cycles, m_rdata=0x00500093
//    -> i_ack pulse, i_rdata=0x00500093, cpu_stall low the cycle after.
//  2 I and D same cycle:
//    d_req load 0x2000 and i_req 0x1004
//    -> D granted first, m_addr=0x2000; then I with no idle gap.
//  3 Starvation:
//    d_req held with 5 back-to-back stores while i_req=1, MAX_D_BURST=4
//    -> grant order D,D,D,D,I,D.
//  4 Store attributes:
//    d_we=1, d_sel=0x0F, d_wdata=0xDEADBEEF
//    -> m_we=1, m_sel=0x0F, m_wdata matches while m_req=1.
//  5 Reset mid-access:
//    rst during GNT_D
//    -> m_req=0 asynchronously, no d_ack, state IDLE after release.
//  6 Timeout (MEM_ARB_TIMEOUT_EN):
//    load 0x3000, m_ack never arrives
//    -> d_ack after 16 cycles, then exc_en=1, exc_code=5, exc_val=0x3000.
//    Without the macro: no ack, exc_en stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the memory arbiter and the exception mux.
// Arbiter states and access-fault exception codes.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] EXC_INSTR_ACCESS = 4'd1;
    localparam logic [3:0] EXC_LOAD_ACCESS  = 4'd5;
    localparam logic [3:0] EXC_STORE_ACCESS = 4'd7;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts cycles a granted access waits for m_ack.
// Stops at TIMEOUT_CYCLES and flags expiry; used with MEM_ARB_TIMEOUT_EN.
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] tmo_cnt;

    assign expired = (tmo_cnt == LIMIT);

    // wait counter: cleared per grant, holds once expired
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (clear) begin
            tmo_cnt <= '0;
        end else if (enable && !expired) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (I) and load/store (D).
// Optional bus timeout with access-fault report when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int MAX_D_BURST    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_sel,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_sel,
    input  logic        m_ack,
    input  logic [63:0] m_rdata,
    output logic        cpu_stall,
    output logic        exc_en,
    output logic [3:0]  exc_code,
    output logic [63:0] exc_val
);
    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

    if (MAX_D_BURST < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("mem_arbiter: bad parameters");
    end

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nxt;
    logic          gnt_i;
    logic          gnt_d;
    logic          starve;
    logic          pick_d;
    logic          pick_i;
    logic          abort;
    logic [3:0]    fault_code;
    logic [63:0]   fault_addr;

    assign gnt_i  = (state == GNT_I);
    assign gnt_d  = (state == GNT_D);
    assign starve = i_req && (burst_cnt == BURST_MAX);
    assign pick_d = d_req && !starve;
    assign pick_i = i_req && !pick_d;

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state == IDLE) || m_ack),
        .enable (state != IDLE),
        .expired(expired)
    );

    assign abort = (state != IDLE) && expired && !m_ack;
`else
    assign abort = 1'b0;
`endif

    // grant state and D burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // arbitrate when idle or when the current access completes
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        if (abort) begin
            state_nxt = IDLE;
        end else if ((state == IDLE) || m_ack) begin
            unique case (1'b1)
                pick_d: begin
                    state_nxt = GNT_D;
                    if (i_req && (burst_cnt != BURST_MAX)) begin
                        burst_nxt = burst_cnt + 1'b1;
                    end
                end
                pick_i: begin
                    state_nxt = GNT_I;
                    burst_nxt = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // memory-side attributes follow the current owner
    always_comb begin
        m_req   = (state != IDLE);
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_sel   = '0;
        case (state)
            GNT_I: begin
                m_addr = i_addr;
                m_sel  = 8'hFF;
            end
            GNT_D: begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_sel   = d_sel;
            end
            default: ;
        endcase
    end

    // acks and read data returned in the m_ack cycle
    always_comb begin
        i_ack     = gnt_i && (m_ack || abort);
        d_ack     = gnt_d && (m_ack || abort);
        i_rdata   = (gnt_i && m_ack) ? m_rdata[31:0] : 32'd0;
        d_rdata   = (gnt_d && m_ack) ? m_rdata : 64'd0;
        cpu_stall = (i_req && !i_ack) || (d_req && !d_ack);
    end

    // fault cause of the access being aborted
    always_comb begin
        fault_code = EXC_INSTR_ACCESS;
        fault_addr = i_addr;
        if (gnt_d) begin
            fault_code = d_we ? EXC_STORE_ACCESS : EXC_LOAD_ACCESS;
            fault_addr = d_addr;
        end
    end

    // access-fault report, one cycle after the abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_en   <= 1'b0;
            exc_code <= '0;
            exc_val  <= '0;
        end else begin
            exc_en <= abort;
            if (abort) begin
                exc_code <= fault_code;
                exc_val  <= fault_addr;
            end
        end
    end

endmodule
